clk_div_prog: RTL and testbench

CLK_DIV_PROG -- requirements
Module: clk_div_prog

---
 rtl/clk_div_pkg.sv | 12 +
 rtl/half_period_counter.sv | 30 +++
 rtl/clk_div_prog.sv | 99 +++++++++
 tb/tb_clk_div_prog.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared types and constants for the programmable clock divider.
// Holds the FSM encoding and the rising-edge counter width.
package clk_div_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int EDGE_W = 16;

endpackage

// File: rtl/half_period_counter.sv
// Cycle counter inside one half-period of clk_out.
// Flags the boundary cycle where clk_out must toggle.
module half_period_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [WIDTH-1:0] hp,
    output logic             boundary
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] cnt;

    assign boundary = run && (cnt == (hp - ONE));

    // Count cycles while running; restart at each boundary and when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!run || boundary) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + ONE;
        end
    end

endmodule

// File: rtl/clk_div_prog.sv
// Programmable clock divider with run/idle FSM and deferred reload.
// New half-periods take effect only at a boundary to keep clk_out clean.
module clk_div_prog
    import clk_div_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int RESET_HP = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [WIDTH-1:0]  div_val,
    input  logic              load,
    output logic              clk_out,
    output logic              tick,
    output logic [EDGE_W-1:0] edge_cnt,
    output logic              busy
);

    localparam logic [WIDTH-1:0]  ONE    = WIDTH'(1);
    localparam logic [EDGE_W-1:0] EC_ONE = EDGE_W'(1);
    localparam logic [WIDTH-1:0]  HP_RST = WIDTH'(RESET_HP);

    state_t           state;
    logic [WIDTH-1:0] hp;
    logic [WIDTH-1:0] pending;
    logic [WIDTH-1:0] load_val;
    logic             run;
    logic             boundary;

    // A zero request would stall the counter, so it means one cycle.
    assign load_val = (div_val == '0) ? ONE : div_val;
    assign run      = (state == RUN) && en;

    half_period_counter #(
        .WIDTH (WIDTH)
    ) u_hpc (
        .clk      (clk),
        .rst_n    (rst_n),
        .run      (run),
        .hp       (hp),
        .boundary (boundary)
    );

    // FSM, reload handling and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            hp       <= HP_RST;
            pending  <= '0;
            busy     <= 1'b0;
            clk_out  <= 1'b0;
            tick     <= 1'b0;
            edge_cnt <= '0;
        end else begin
            tick <= 1'b0;
            unique case (state)
                IDLE: begin
                    clk_out <= 1'b0;
                    busy    <= 1'b0;
                    if (load) begin
                        hp <= load_val;
                    end
                    if (en) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (!en) begin
                        state   <= IDLE;
                        clk_out <= 1'b0;
                        busy    <= 1'b0;
                        if (load) begin
                            hp <= load_val;
                        end else if (busy) begin
                            hp <= pending;
                        end
                    end else if (boundary) begin
                        clk_out <= ~clk_out;
                        busy    <= 1'b0;
                        if (!clk_out) begin
                            tick     <= 1'b1;
                            edge_cnt <= edge_cnt + EC_ONE;
                        end
                        if (load) begin
                            hp <= load_val;
                        end else if (busy) begin
                            hp <= pending;
                        end
                    end else if (load) begin
                        pending <= load_val;
                        busy    <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clk_div_prog.sv
// Randomized bench for clk_div_prog against a countdown model.
// Directed scenarios first, then random en/load traffic with resets.
module tb_clk_div_prog;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [7:0]  div_val;
    logic        load;
    logic        clk_out;
    logic        tick;
    logic [15:0] edge_cnt;
    logic        busy;

    int errs;
    int checks;

    int m_hp;
    int m_pend;
    int m_rem;
    int m_ec;
    bit m_run;
    bit m_busy;
    bit m_out;
    bit m_tick;

    clk_div_prog #(
        .WIDTH    (8),
        .RESET_HP (1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .div_val  (div_val),
        .load     (load),
        .clk_out  (clk_out),
        .tick     (tick),
        .edge_cnt (edge_cnt),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
        end
    endtask

    function automatic int nz(input int v);
        return (v == 0) ? 1 : v;
    endfunction

    function automatic logic [31:0] exp_vec();
        logic [15:0] ec;
        ec = m_ec[15:0];
        return 32'({m_out, m_tick, m_busy, ec});
    endfunction

    function automatic logic [31:0] dut_vec();
        return 32'({clk_out, tick, busy, edge_cnt});
    endfunction

    task automatic model_reset();
        m_hp   = 1;
        m_pend = 0;
        m_rem  = 0;
        m_ec   = 0;
        m_run  = 0;
        m_busy = 0;
        m_out  = 0;
        m_tick = 0;
    endtask

    // Remaining-cycles countdown: toggle when it reaches zero.
    task automatic model_step(input bit e, input bit l, input int d);
        m_tick = 0;
        if (!m_run) begin
            if (l) m_hp = nz(d);
            m_busy = 0;
            m_out  = 0;
            if (e) begin
                m_run = 1;
                m_rem = m_hp;
            end
        end else if (!e) begin
            m_run = 0;
            m_out = 0;
            if (l) m_hp = nz(d);
            else if (m_busy) m_hp = m_pend;
            m_busy = 0;
        end else begin
            m_rem--;
            if (m_rem == 0) begin
                m_out = !m_out;
                if (m_out) begin
                    m_tick = 1;
                    m_ec = (m_ec + 1) % 65536;
                end
                if (l) m_hp = nz(d);
                else if (m_busy) m_hp = m_pend;
                m_busy = 0;
                m_rem  = m_hp;
            end else if (l) begin
                m_pend = nz(d);
                m_busy = 1;
            end
        end
    endtask

    task automatic step(input bit e, input bit l, input int d);
        en      = e;
        load    = l;
        div_val = d[7:0];
        @(posedge clk);
        model_step(e, l, d);
        #1;
        chk("cyc", dut_vec(), exp_vec());
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst", dut_vec(), exp_vec());
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        errs    = 0;
        checks  = 0;
        rst_n   = 1'b1;
        en      = 1'b0;
        load    = 1'b0;
        div_val = '0;
        model_reset();
        #1;
        do_reset();

        // Default hp=1: five rises in ten cycles.
        step(1, 0, 0);
        for (int i = 0; i < 10; i++) step(1, 0, 0);
        chk("r031_ec", 32'(edge_cnt), 32'd5);

        // Idle load of 3, first rise three cycles after entering run.
        do_reset();
        step(0, 1, 3);
        chk("r032_busy", 32'(busy), 32'd0);
        step(1, 0, 0);
        step(1, 0, 0);
        step(1, 0, 0);
        chk("r032_low", 32'(clk_out), 32'd0);
        step(1, 0, 0);
        chk("r032_rise", 32'(clk_out), 32'd1);
        for (int i = 0; i < 12; i++) step(1, 0, 0);

        // Reload during run is deferred to the boundary.
        do_reset();
        step(0, 1, 4);
        step(1, 0, 0);
        step(1, 0, 0);
        step(1, 1, 2);
        chk("r033_busy1", 32'(busy), 32'd1);
        step(1, 0, 0);
        chk("r033_busy2", 32'(busy), 32'd1);
        step(1, 0, 0);
        chk("r033_bnd", 32'({clk_out, busy}), 32'b10);
        step(1, 0, 0);
        step(1, 0, 0);
        chk("r033_hp2", 32'(clk_out), 32'd0);
        for (int i = 0; i < 8; i++) step(1, 0, 0);

        // Zero request behaves as one.
        step(0, 1, 0);
        step(1, 0, 0);
        step(1, 0, 0);
        chk("r034_hi", 32'(clk_out), 32'd1);
        step(1, 0, 0);
        chk("r034_lo", 32'(clk_out), 32'd0);

        // Rising-edge counter wrap.
        step(0, 0, 0);
        force dut.edge_cnt = 16'hFFFE;
        #1;
        release dut.edge_cnt;
        m_ec = 16'hFFFE;
        chk("r035_set", 32'(edge_cnt), 32'h0000FFFE);
        step(1, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 0, 0);
        chk("r035_wrap", 32'(edge_cnt), 32'd0);
        for (int i = 0; i < 4; i++) step(1, 0, 0);

        // Reset while a reload is pending.
        step(0, 1, 4);
        step(1, 0, 0);
        step(1, 1, 3);
        chk("r036_pend", 32'(busy), 32'd1);
        do_reset();
        step(1, 0, 0);
        step(1, 0, 0);
        chk("r036_hp", 32'(clk_out), 32'd1);
        for (int i = 0; i < 6; i++) step(1, 0, 0);

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 15) != 0,
                     $urandom_range(0, 7) == 0,
                     int'($urandom_range(0, 5)));
            end
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
